// File: rtl/image_writeback.sv
// Raster-order writeback of a blurred pixel stream into an output SRAM, with a small stall FIFO.
// Latency: a pixel arriving at an empty FIFO with the SRAM port free is written one cycle later.
// Backpressure: mem_stall holds pixels in the FIFO; overflow, extra and out-of-frame pixels are dropped and flag err.
// Optional: define WB_CHECKSUM_EN to add the frame_sum output (16-bit running sum of written pixels).
module image_writeback #(
    parameter int X_MAX       = 16,
    parameter int Y_MAX       = 16,
    parameter int PIXEL_DEPTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     new_trans,
    input  logic [$clog2(X_MAX):0]   img_w,
    input  logic [$clog2(Y_MAX):0]   img_h,
    input  logic                     pix_valid,
    input  logic [PIXEL_DEPTH-1:0]   pix_data,
    input  logic                     blur_complete,
    input  logic                     mem_stall,
    output logic [$clog2(X_MAX):0]   x_addr,
    output logic [$clog2(Y_MAX):0]   y_addr,
    output logic [PIXEL_DEPTH-1:0]   wdat,
    output logic                     wen,
    output logic                     busy,
    output logic                     frame_done,
`ifdef WB_CHECKSUM_EN
    output logic [15:0]              frame_sum,
`endif
    output logic                     err
);
    localparam int XW = $clog2(X_MAX) + 1;
    localparam int YW = $clog2(Y_MAX) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = XW + YW;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WRITE, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [XW-1:0]          w_lat, x_cnt;
    logic [YW-1:0]          h_lat, y_cnt;
    logic [TW-1:0]          recv_cnt, total;
    logic [PIXEL_DEPTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [PW:0]            count;

    logic size_ok, active, full, empty, more, push_req;
    logic pop, push, store, take, drop, bc_err, last_pop;
    logic [PIXEL_DEPTH-1:0] pop_dat;

    assign size_ok  = (img_w != '0) && (img_h != '0);
    assign active   = (state == S_ARMED) || (state == S_WRITE);
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign total    = TW'(w_lat) * TW'(h_lat);
    assign more     = (recv_cnt < total);
    assign push_req = active && !new_trans && pix_valid && more;
    // An empty FIFO forwards the incoming pixel straight to the write stage.
    assign pop      = active && !new_trans && !mem_stall && (!empty || push_req);
    assign push     = push_req && (!full || pop);
    assign store    = push && !(empty && pop);
    assign take     = pop && !empty;
    assign pop_dat  = empty ? pix_data : mem[rd_ptr];
    assign drop     = pix_valid && !new_trans && !push;
    assign bc_err   = blur_complete && active && !new_trans && ((recv_cnt + TW'(push)) < total);
    assign last_pop = pop && (x_cnt == w_lat - XW'(1)) && (y_cnt == h_lat - YW'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; new_trans restarts from any state.
    always_comb begin
        state_nxt = state;
        if (new_trans) begin
            state_nxt = size_ok ? S_ARMED : S_IDLE;
        end else begin
            case (state)
                S_ARMED: if (pop) state_nxt = last_pop ? S_DONE : S_WRITE;
                S_WRITE: if (last_pop) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // State-decoded outputs.
    always_comb begin
        busy       = (state == S_ARMED) || (state == S_WRITE);
        frame_done = (state == S_DONE);
    end

    // Frame size latch and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_lat <= '0;
            h_lat <= '0;
            err   <= 1'b0;
        end else if (new_trans) begin
            w_lat <= img_w;
            h_lat <= img_h;
            err   <= !size_ok;
        end else if (drop || bc_err) begin
            err   <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= pix_data;
    end

    // FIFO pointers, occupancy and received-pixel count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            recv_cnt <= '0;
        end else if (new_trans) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            recv_cnt <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + PW'(1);
            if (take)  rd_ptr <= rd_ptr + PW'(1);
            count    <= count + (PW+1)'(store) - (PW+1)'(take);
            recv_cnt <= recv_cnt + TW'(push);
        end
    end

    // Registered SRAM write port and raster address counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen    <= 1'b0;
            wdat   <= '0;
            x_addr <= '0;
            y_addr <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            wen <= pop;
            if (new_trans) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (pop) begin
                wdat   <= pop_dat;
                x_addr <= x_cnt;
                y_addr <= y_cnt;
                if (last_pop) begin
                    x_cnt <= '0;
                    y_cnt <= '0;
                end else if (x_cnt == w_lat - XW'(1)) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + YW'(1);
                end else begin
                    x_cnt <= x_cnt + XW'(1);
                end
            end
        end
    end

`ifdef WB_CHECKSUM_EN
    // Running sum of written pixels; holds after the frame until the next new_trans.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            frame_sum <= '0;
        else if (new_trans) frame_sum <= '0;
        else if (pop)       frame_sum <= frame_sum + 16'(pop_dat);
    end
`endif
endmodule

// File: tb/tb_image_writeback.sv
// Directed bench for image_writeback: per-cycle vector table plus multi-cycle frame sequences.
// Outputs are sampled 1ns after the rising edge; written pixels are logged on the falling edge.
// Expected values are hand-computed from the raster and FIFO rules.
module tb_image_writeback;
    logic       clk, rst, new_trans, pix_valid, blur_complete, mem_stall;
    logic [4:0] img_w, img_h, x_addr, y_addr;
    logic [7:0] pix_data, wdat;
    logic       wen, busy, frame_done, err;
`ifdef WB_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    image_writeback #(.X_MAX(16), .Y_MAX(16), .PIXEL_DEPTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .new_trans(new_trans), .img_w(img_w), .img_h(img_h),
        .pix_valid(pix_valid), .pix_data(pix_data), .blur_complete(blur_complete),
        .mem_stall(mem_stall), .x_addr(x_addr), .y_addr(y_addr), .wdat(wdat), .wen(wen),
        .busy(busy), .frame_done(frame_done),
`ifdef WB_CHECKSUM_EN
        .frame_sum(frame_sum),
`endif
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // Write log filled on the falling edge.
    int wr_n = 0;
    int done_n = 0;
    int wr_x [512];
    int wr_y [512];
    int wr_d [512];
    always @(negedge clk) begin
        if (wen && wr_n < 512) begin
            wr_x[wr_n] = x_addr;
            wr_y[wr_n] = y_addr;
            wr_d[wr_n] = wdat;
            wr_n++;
        end
        if (frame_done) done_n++;
    end

    typedef struct {
        bit nt; int w; int h; bit pv; int pd; bit st; bit bc;
        bit ewen; int ex; int ey; int ed; bit ebusy; bit efd; bit eerr;
    } vec_t;
    vec_t vecs [32];
    int nv = 0;

    task automatic addv(input bit nt, input int w, input int h, input bit pv, input int pd,
                        input bit st, input bit bc, input bit ewen, input int ex, input int ey,
                        input int ed, input bit ebusy, input bit efd, input bit eerr);
        vecs[nv] = '{nt, w, h, pv, pd, st, bc, ewen, ex, ey, ed, ebusy, efd, eerr};
        nv++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit nt, input int w, input int h, input bit pv, input int pd,
                         input bit st, input bit bc);
        new_trans = nt; img_w = 5'(w); img_h = 5'(h);
        pix_valid = pv; pix_data = 8'(pd); mem_stall = st; blur_complete = bc;
    endtask

    task automatic idle(input int n, input bit st);
        drive(0, 0, 0, 0, 0, st, 0);
        repeat (n) cyc();
    endtask

    int b, db;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wen", wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", err, 0);
        chk("rst_x", x_addr, 0);
        chk("rst_y", y_addr, 0);
        chk("rst_wdat", wdat, 0);
        rst = 1'b0;
        cyc();

        // nt w h pv pd st bc | wen x y d busy done err
        addv(1, 2, 2, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        addv(0, 0, 0, 1, 10, 0, 0,  1, 0, 0, 10, 1, 0, 0);
        addv(0, 0, 0, 1, 11, 1, 0,  0, 0, 0,  0, 1, 0, 0);
        addv(0, 0, 0, 1, 12, 1, 0,  0, 0, 0,  0, 1, 0, 0);
        addv(0, 0, 0, 0,  0, 0, 0,  1, 1, 0, 11, 1, 0, 0);
        addv(0, 0, 0, 1, 13, 0, 0,  1, 0, 1, 12, 1, 0, 0);
        addv(0, 0, 0, 0,  0, 0, 0,  1, 1, 1, 13, 0, 1, 0);
        addv(0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        addv(0, 0, 0, 1, 99, 0, 0,  0, 0, 0,  0, 0, 0, 1);
        addv(1, 0, 2, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 1);
        addv(1, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        addv(0, 0, 0, 1,  7, 0, 0,  1, 0, 0,  7, 0, 1, 0);
        addv(0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
        addv(1, 2, 1, 0,  0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
        addv(0, 0, 0, 0,  0, 0, 1,  0, 0, 0,  0, 1, 0, 1);
        addv(0, 0, 0, 1,  5, 0, 0,  1, 0, 0,  5, 1, 0, 1);
        addv(0, 0, 0, 1,  6, 0, 0,  1, 1, 0,  6, 0, 1, 1);

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].nt, vecs[i].w, vecs[i].h, vecs[i].pv, vecs[i].pd, vecs[i].st, vecs[i].bc);
            cyc();
            chk($sformatf("v%0d_wen", i), wen, vecs[i].ewen);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].ebusy);
            chk($sformatf("v%0d_done", i), frame_done, vecs[i].efd);
            chk($sformatf("v%0d_err", i), err, vecs[i].eerr);
            if (vecs[i].ewen) begin
                chk($sformatf("v%0d_x", i), x_addr, vecs[i].ex);
                chk($sformatf("v%0d_y", i), y_addr, vecs[i].ey);
                chk($sformatf("v%0d_wdat", i), wdat, vecs[i].ed);
            end
        end
        idle(2, 0);

        // 4x4 frame, one pixel per cycle, no stalls; blur_complete with the last pixel.
        b = wr_n; db = done_n;
        drive(1, 4, 4, 0, 0, 0, 0);
        cyc();
        chk("a_wen_before_pix", wen, 0);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, i, 0, (i == 15));
            cyc();
            if (i == 0) chk("a_first_wen_latency", wen, 1);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (2) cyc();
        idle(2, 0);
        chk("a_count", wr_n - b, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("a_x%0d", i), wr_x[b+i], i % 4);
            chk($sformatf("a_y%0d", i), wr_y[b+i], i / 4);
            chk($sformatf("a_d%0d", i), wr_d[b+i], i);
        end
        chk("a_done_once", done_n - db, 1);
        chk("a_err", err, 0);
        chk("a_busy_after", busy, 0);

        // Same frame, stalled 3 of every 4 cycles, one pixel every 4th cycle.
        b = wr_n; db = done_n;
        drive(1, 4, 4, 0, 0, 0, 0);
        cyc();
        for (int k = 0; k < 64; k++) begin
            drive(0, 0, 0, (k % 4 == 0), k / 4, (k % 4 != 3), 0);
            cyc();
        end
        idle(3, 0);
        chk("b_count", wr_n - b, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b_d%0d", i), wr_d[b+i], i);
            chk($sformatf("b_xy%0d", i), wr_y[b+i] * 4 + wr_x[b+i], i);
        end
        chk("b_done_once", done_n - db, 1);
        chk("b_err", err, 0);

        // Permanent stall: four pixels fit, the fifth is dropped.
        b = wr_n;
        drive(1, 4, 4, 0, 0, 1, 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 20 + i, 1, 0);
            cyc();
        end
        idle(3, 1);
        chk("c_no_wen", wr_n - b, 0);
        chk("c_err", err, 1);
        chk("c_busy", busy, 1);
        idle(6, 0);
        chk("c_drain_count", wr_n - b, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("c_d%0d", i), wr_d[b+i], 20 + i);

        // 3x2 frame followed by a stray seventh pixel.
        b = wr_n; db = done_n;
        drive(1, 3, 2, 0, 0, 0, 0);
        cyc();
        chk("d_err_cleared", err, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 1, 30 + i, 0, 0);
            cyc();
        end
        idle(3, 0);
        chk("d_done_once", done_n - db, 1);
        chk("d_err_before_extra", err, 0);
        drive(0, 0, 0, 1, 36, 0, 0);
        cyc();
        idle(2, 0);
        chk("d_count", wr_n - b, 6);
        chk("d_last_d", wr_d[b+5], 35);
        chk("d_last_xy", wr_y[b+5] * 4 + wr_x[b+5], 6);
        chk("d_err_extra", err, 1);
        drive(1, 3, 2, 0, 0, 0, 0);
        cyc();
        chk("d_nt_clears_err", err, 0);
        idle(1, 0);

`ifdef WB_CHECKSUM_EN
        drive(1, 2, 2, 0, 0, 0, 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 255, 0, 0);
            cyc();
        end
        idle(3, 0);
        chk("e_frame_sum", frame_sum, 1020);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
